// File: rtl/xbar_nport_arb_if.sv
// Bus bundle for the N-port packet crossbar: per-input beat channels in,
// per-output registered beat channels out, each with valid/ready handshake.
interface xbar_nport_arb_if #(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int NUM_PORTS         = 4
);
  localparam int DEST_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS*AURORA_DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]                   in_valid;
  logic [NUM_PORTS-1:0]                   in_last;
  logic [NUM_PORTS*DEST_W-1:0]            in_dest;
  logic [NUM_PORTS-1:0]                   in_ready;

  logic [NUM_PORTS*AURORA_DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]                   out_valid;
  logic [NUM_PORTS-1:0]                   out_last;
  logic [NUM_PORTS*DEST_W-1:0]            out_src;
  logic [NUM_PORTS-1:0]                   out_ready;

  // Crossbar side
  modport slave (
    input  in_data, in_valid, in_last, in_dest, out_ready,
    output in_ready, out_data, out_valid, out_last, out_src
  );

  // Traffic source / sink side
  modport master (
    output in_data, in_valid, in_last, in_dest, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_src
  );
endinterface

// File: rtl/xbar_nport_arb.sv
// N-input / N-output packet crossbar. Each output runs its own round-robin
// arbiter over first beats addressed to it, locks onto the winner until the
// last beat, and presents beats through a one-deep registered output stage.
// First beats with an out-of-range destination are swallowed whole and counted.
module xbar_nport_arb #(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int NUM_PORTS         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  xbar_nport_arb_if.slave bus,
  output logic [15:0]     drop_count
);
  localparam int DEST_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int DW     = AURORA_DATA_WIDTH;
  localparam logic [DEST_W:0] PORT_LIMIT = (DEST_W+1)'(NUM_PORTS);

  typedef enum logic {IDLE, LOCKED} out_state_e;

  logic [DW-1:0]        in_data_a  [NUM_PORTS];
  logic [DEST_W-1:0]    in_dest_a  [NUM_PORTS];
  logic [NUM_PORTS-1:0] dest_ok;
  logic [NUM_PORTS-1:0] first_q;
  logic [NUM_PORTS-1:0] drop_q;
  logic [NUM_PORTS-1:0] drop_start;
  logic [NUM_PORTS-1:0] in_ready_c;
  logic [NUM_PORTS-1:0] accept;

  out_state_e           state_q    [NUM_PORTS];
  out_state_e           state_d    [NUM_PORTS];
  logic [DEST_W-1:0]    owner_q    [NUM_PORTS];
  logic [DEST_W-1:0]    owner_d    [NUM_PORTS];
  logic [DEST_W-1:0]    rr_q       [NUM_PORTS];
  logic [DEST_W-1:0]    rr_d       [NUM_PORTS];
  logic [DEST_W-1:0]    grant_idx  [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant_vld;
  logic [NUM_PORTS-1:0] stage_free;
  logic [NUM_PORTS-1:0] xfer;

  logic [DW-1:0]        out_data_q [NUM_PORTS];
  logic [DEST_W-1:0]    out_src_q  [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_valid_q;
  logic [NUM_PORTS-1:0] out_last_q;

  logic [16:0]          drop_sum;
  logic [15:0]          drop_count_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign in_data_a[p] = bus.in_data[p*DW +: DW];
    assign in_dest_a[p] = bus.in_dest[p*DEST_W +: DEST_W];
    assign dest_ok[p]   = ({1'b0, in_dest_a[p]} < PORT_LIMIT);
    assign bus.out_data[p*DW +: DW]         = out_data_q[p];
    assign bus.out_src[p*DEST_W +: DEST_W]  = out_src_q[p];
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.in_ready  = in_ready_c;
  assign accept        = bus.in_valid & in_ready_c;
  assign drop_count    = drop_count_q;

  // Per-output grant: the owner while locked, else round-robin over first-beat requesters
  always_comb begin
    logic [DEST_W-1:0] cand;
    cand = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      grant_vld[o]  = 1'b0;
      grant_idx[o]  = '0;
      stage_free[o] = !out_valid_q[o] || bus.out_ready[o];
      if (state_q[o] == LOCKED) begin
        grant_idx[o] = owner_q[o];
        grant_vld[o] = bus.in_valid[owner_q[o]];
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          cand = DEST_W'((int'(rr_q[o]) + k) % NUM_PORTS);
          if (!grant_vld[o] && bus.in_valid[cand] && first_q[cand] &&
              in_dest_a[cand] == DEST_W'(o)) begin
            grant_vld[o] = 1'b1;
            grant_idx[o] = cand;
          end
        end
      end
      xfer[o] = grant_vld[o] && stage_free[o];
    end
  end

  // Input ready: granted with a free stage, or swallowing a bad-destination packet
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready_c[i] = drop_q[i] || (bus.in_valid[i] && first_q[i] && !dest_ok[i]);
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (xfer[o]) begin
        in_ready_c[grant_idx[o]] = 1'b1;
      end
    end
  end

  // Output FSM next state: lock on a multi-beat first beat, release on the last beat
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      if (xfer[o]) begin
        if (state_q[o] == IDLE) begin
          rr_d[o] = DEST_W'((int'(grant_idx[o]) + 1) % NUM_PORTS);
          if (!bus.in_last[grant_idx[o]]) begin
            state_d[o] = LOCKED;
            owner_d[o] = grant_idx[o];
          end
        end else if (bus.in_last[grant_idx[o]]) begin
          state_d[o] = IDLE;
        end
      end
    end
  end

  // Output FSM state, owner and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

  // Registered output stage: load on transfer, drain when downstream accepts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_last_q  <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_data_q[o] <= '0;
        out_src_q[o]  <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (xfer[o]) begin
          out_valid_q[o] <= 1'b1;
          out_last_q[o]  <= bus.in_last[grant_idx[o]];
          out_data_q[o]  <= in_data_a[grant_idx[o]];
          out_src_q[o]   <= grant_idx[o];
        end else if (bus.out_ready[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counter increment: one per bad-destination packet start
  always_comb begin
    drop_sum = {1'b0, drop_count_q};
    for (int i = 0; i < NUM_PORTS; i++) begin
      drop_start[i] = accept[i] && first_q[i] && !dest_ok[i];
      if (drop_start[i]) begin
        drop_sum = drop_sum + 17'd1;
      end
    end
    if (drop_sum > 17'h0FFFF) begin
      drop_sum = 17'h0FFFF;
    end
  end

  // Per-input packet framing: first-beat flag, drop mode and drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q      <= '1;
      drop_q       <= '0;
      drop_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (accept[i]) begin
          first_q[i] <= bus.in_last[i];
          drop_q[i]  <= (drop_q[i] || (first_q[i] && !dest_ok[i])) && !bus.in_last[i];
        end
      end
      drop_count_q <= drop_sum[15:0];
    end
  end
endmodule

// File: tb/tb_xbar_nport_arb.sv
// Directed self-checking bench for xbar_nport_arb: a 4-port instance for the
// routing, arbitration, backpressure and reset scenarios and a 3-port instance
// for the out-of-range destination case. Inputs change 1 time unit after the
// rising edge; everything is checked on the following falling edge.
module tb_xbar_nport_arb;
  localparam int DW = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] drop_count4;
  logic [15:0] drop_count3;
  int          assert_count = 0;
  int          fail_count   = 0;

  xbar_nport_arb_if #(.AURORA_DATA_WIDTH(DW), .NUM_PORTS(4)) bus4 ();
  xbar_nport_arb_if #(.AURORA_DATA_WIDTH(DW), .NUM_PORTS(3)) bus3 ();

  xbar_nport_arb #(.AURORA_DATA_WIDTH(DW), .NUM_PORTS(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus4),
    .drop_count (drop_count4)
  );

  xbar_nport_arb #(.AURORA_DATA_WIDTH(DW), .NUM_PORTS(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus3),
    .drop_count (drop_count3)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=still_running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] out_data4(input logic [1:0] o);
    return bus4.out_data[o*DW +: DW];
  endfunction

  function automatic logic [1:0] out_src4(input logic [1:0] o);
    return bus4.out_src[o*2 +: 2];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [1:0] p, input logic v, input logic [DW-1:0] d,
                        input logic [1:0] dest, input logic last);
    bus4.in_valid[p]          = v;
    bus4.in_last[p]           = last;
    bus4.in_data[p*DW +: DW]  = d;
    bus4.in_dest[p*2 +: 2]    = dest;
  endtask

  task automatic drive3(input logic [1:0] p, input logic v, input logic [DW-1:0] d,
                        input logic [1:0] dest, input logic last);
    bus3.in_valid[p]          = v;
    bus3.in_last[p]           = last;
    bus3.in_data[p*DW +: DW]  = d;
    bus3.in_dest[p*2 +: 2]    = dest;
  endtask

  task automatic clear_inputs();
    bus4.in_valid = '0; bus4.in_last = '0; bus4.in_data = '0; bus4.in_dest = '0;
    bus3.in_valid = '0; bus3.in_last = '0; bus3.in_data = '0; bus3.in_dest = '0;
  endtask

  // Two reset cycles, then idle: nothing valid, nothing ready, counter zero
  task automatic test_reset();
    clear_inputs();
    bus4.out_ready = '1;
    bus3.out_ready = '1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    assert_count++;
    if (bus4.out_valid !== 4'b0000) begin
      $display("[TB] FAIL reset_out_valid actual=%b required=0000", bus4.out_valid); fail_count++;
    end
    assert_count++;
    if (drop_count4 !== 16'd0) begin
      $display("[TB] FAIL reset_drop_count actual=%0d required=0", drop_count4); fail_count++;
    end
    assert_count++;
    if (bus4.in_ready !== 4'b0000) begin
      $display("[TB] FAIL reset_in_ready actual=%b required=0000", bus4.in_ready); fail_count++;
    end
    assert_count++;
    if (bus4.out_data !== '0 || bus4.out_src !== '0 || bus4.out_last !== '0) begin
      $display("[TB] FAIL reset_out_regs actual=%h/%h/%b required=0/0/0",
               bus4.out_data, bus4.out_src, bus4.out_last); fail_count++;
    end
    assert_count++;
    if (bus3.out_valid !== 3'b000 || drop_count3 !== 16'd0) begin
      $display("[TB] FAIL reset_port3 actual=%b/%0d required=000/0", bus3.out_valid, drop_count3);
      fail_count++;
    end
    next_cycle();
  endtask

  // Input 2 sends A0,A1,A2 to output 1; each beat appears one cycle later
  task automatic test_unicast();
    logic [DW-1:0] beats [3];
    beats = '{64'hA0, 64'hA1, 64'hA2};
    for (int b = 0; b < 3; b++) begin
      drive4(2'd2, 1'b1, beats[b], 2'd1, (b == 2));
      @(negedge clk);
      assert_count++;
      if (bus4.in_ready !== 4'b0100) begin
        $display("[TB] FAIL unicast_ready beat=%0d actual=%b required=0100", b, bus4.in_ready);
        fail_count++;
      end
      if (b > 0) begin
        assert_count++;
        if (bus4.out_valid !== 4'b0010 || out_data4(2'd1) !== beats[b-1] ||
            out_src4(2'd1) !== 2'd2 || bus4.out_last[1] !== 1'b0) begin
          $display("[TB] FAIL unicast_out beat=%0d actual=%b/%h/%0d/%b required=0010/%h/2/0",
                   b-1, bus4.out_valid, out_data4(2'd1), out_src4(2'd1), bus4.out_last[1], beats[b-1]);
          fail_count++;
        end
      end
      next_cycle();
    end
    drive4(2'd2, 1'b0, '0, 2'd0, 1'b0);
    @(negedge clk);
    assert_count++;
    if (bus4.out_valid !== 4'b0010 || out_data4(2'd1) !== 64'hA2 ||
        out_src4(2'd1) !== 2'd2 || bus4.out_last[1] !== 1'b1) begin
      $display("[TB] FAIL unicast_last actual=%b/%h/%0d/%b required=0010/a2/2/1",
               bus4.out_valid, out_data4(2'd1), out_src4(2'd1), bus4.out_last[1]);
      fail_count++;
    end
    next_cycle();
    @(negedge clk);
    assert_count++;
    if (bus4.out_valid !== 4'b0000) begin
      $display("[TB] FAIL unicast_drain actual=%b required=0000", bus4.out_valid); fail_count++;
    end
    next_cycle();
  endtask

  // Inputs 0 and 3 contend for output 0; input 0 wins, then input 3 wins
  // the rematch against input 0's immediate second packet
  task automatic test_contention();
    logic          v0 [8], l0 [8], v3 [8], l3 [8], ov [8], ol [8];
    logic [DW-1:0] d0 [8], d3 [8], od [8];
    logic [1:0]    os [8];
    logic [3:0]    rdy [8];
    v0  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    d0  = '{64'hB0, 64'hB1, 64'hD0, 64'hD0, 64'hD0, 64'hD1, 64'h0, 64'h0};
    l0  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v3  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    d3  = '{64'hC0, 64'hC0, 64'hC0, 64'hC1, 64'h0, 64'h0, 64'h0, 64'h0};
    l3  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rdy = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    ov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    od  = '{64'h0, 64'hB0, 64'hB1, 64'hC0, 64'hC1, 64'hD0, 64'hD1, 64'h0};
    os  = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    ol  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 8; c++) begin
      drive4(2'd0, v0[c], d0[c], 2'd0, l0[c]);
      drive4(2'd3, v3[c], d3[c], 2'd0, l3[c]);
      @(negedge clk);
      assert_count++;
      if (bus4.in_ready !== rdy[c]) begin
        $display("[TB] FAIL contention_ready cycle=%0d actual=%b required=%b", c, bus4.in_ready, rdy[c]);
        fail_count++;
      end
      assert_count++;
      if (bus4.out_valid[0] !== ov[c]) begin
        $display("[TB] FAIL contention_valid cycle=%0d actual=%b required=%b", c, bus4.out_valid[0], ov[c]);
        fail_count++;
      end
      if (ov[c]) begin
        assert_count++;
        if (out_data4(2'd0) !== od[c] || out_src4(2'd0) !== os[c] || bus4.out_last[0] !== ol[c]) begin
          $display("[TB] FAIL contention_beat cycle=%0d actual=%h/%0d/%b required=%h/%0d/%b",
                   c, out_data4(2'd0), out_src4(2'd0), bus4.out_last[0], od[c], os[c], ol[c]);
          fail_count++;
        end
      end
      next_cycle();
    end
  endtask

  // Input 1 sends E0..E3 to output 1 with out_ready[1] low for four cycles
  task automatic test_backpressure();
    logic          v [10], l [10], orr [10], rdy [10], ov [10], ol [10];
    logic [DW-1:0] d [10], od [10];
    v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    d   = '{64'hE0, 64'hE1, 64'hE2, 64'hE2, 64'hE2, 64'hE2, 64'hE2, 64'hE3, 64'h0, 64'h0};
    l   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    orr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    od  = '{64'h0, 64'hE0, 64'hE1, 64'hE1, 64'hE1, 64'hE1, 64'hE1, 64'hE2, 64'hE3, 64'h0};
    ol  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 10; c++) begin
      drive4(2'd1, v[c], d[c], 2'd1, l[c]);
      bus4.out_ready[1] = orr[c];
      @(negedge clk);
      assert_count++;
      if (bus4.in_ready !== {2'b00, rdy[c], 1'b0}) begin
        $display("[TB] FAIL backpressure_ready cycle=%0d actual=%b required=00%b0", c, bus4.in_ready, rdy[c]);
        fail_count++;
      end
      assert_count++;
      if (bus4.out_valid[1] !== ov[c]) begin
        $display("[TB] FAIL backpressure_valid cycle=%0d actual=%b required=%b", c, bus4.out_valid[1], ov[c]);
        fail_count++;
      end
      if (ov[c]) begin
        assert_count++;
        if (out_data4(2'd1) !== od[c] || out_src4(2'd1) !== 2'd1 || bus4.out_last[1] !== ol[c]) begin
          $display("[TB] FAIL backpressure_beat cycle=%0d actual=%h/%0d/%b required=%h/1/%b",
                   c, out_data4(2'd1), out_src4(2'd1), bus4.out_last[1], od[c], ol[c]);
          fail_count++;
        end
      end
      next_cycle();
    end
  endtask

  // Reset lands on the second beat of a packet; the following 1-beat packet
  // must route by its own destination
  task automatic test_reset_mid_packet();
    drive4(2'd0, 1'b1, 64'hF0, 2'd2, 1'b0);
    @(negedge clk);
    assert_count++;
    if (bus4.in_ready !== 4'b0001) begin
      $display("[TB] FAIL midreset_first_ready actual=%b required=0001", bus4.in_ready); fail_count++;
    end
    next_cycle();
    drive4(2'd0, 1'b1, 64'hF1, 2'd2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    assert_count++;
    if (bus4.out_valid !== 4'b0100 || out_data4(2'd2) !== 64'hF0) begin
      $display("[TB] FAIL midreset_before actual=%b/%h required=0100/f0", bus4.out_valid, out_data4(2'd2));
      fail_count++;
    end
    next_cycle();
    rst_n = 1'b1;
    drive4(2'd0, 1'b1, 64'h60, 2'd3, 1'b1);
    @(negedge clk);
    assert_count++;
    if (bus4.out_valid !== 4'b0000 || bus4.out_data !== '0 || bus4.out_last !== '0) begin
      $display("[TB] FAIL midreset_cleared actual=%b/%h/%b required=0000/0/0",
               bus4.out_valid, bus4.out_data, bus4.out_last); fail_count++;
    end
    assert_count++;
    if (bus4.in_ready !== 4'b0001) begin
      $display("[TB] FAIL midreset_new_ready actual=%b required=0001", bus4.in_ready); fail_count++;
    end
    next_cycle();
    drive4(2'd0, 1'b0, '0, 2'd0, 1'b0);
    @(negedge clk);
    assert_count++;
    if (bus4.out_valid !== 4'b1000 || out_data4(2'd3) !== 64'h60 ||
        out_src4(2'd3) !== 2'd0 || bus4.out_last[3] !== 1'b1) begin
      $display("[TB] FAIL midreset_new_route actual=%b/%h/%0d/%b required=1000/60/0/1",
               bus4.out_valid, out_data4(2'd3), out_src4(2'd3), bus4.out_last[3]); fail_count++;
    end
    assert_count++;
    if (drop_count4 !== 16'd0) begin
      $display("[TB] FAIL midreset_drop_count actual=%0d required=0", drop_count4); fail_count++;
    end
    next_cycle();
    @(negedge clk);
    assert_count++;
    if (bus4.out_valid !== 4'b0000) begin
      $display("[TB] FAIL midreset_drain actual=%b required=0000", bus4.out_valid); fail_count++;
    end
    next_cycle();
  endtask

  // 3-port build: destination 3 is out of range, so the packet is eaten and counted
  task automatic test_invalid_dest();
    drive3(2'd0, 1'b1, 64'h70, 2'd3, 1'b0);
    @(negedge clk);
    assert_count++;
    if (bus3.in_ready !== 3'b001 || drop_count3 !== 16'd0) begin
      $display("[TB] FAIL invalid_first actual=%b/%0d required=001/0", bus3.in_ready, drop_count3);
      fail_count++;
    end
    next_cycle();
    drive3(2'd0, 1'b1, 64'h71, 2'd0, 1'b1);
    @(negedge clk);
    assert_count++;
    if (bus3.in_ready !== 3'b001 || bus3.out_valid !== 3'b000 || drop_count3 !== 16'd1) begin
      $display("[TB] FAIL invalid_second actual=%b/%b/%0d required=001/000/1",
               bus3.in_ready, bus3.out_valid, drop_count3); fail_count++;
    end
    next_cycle();
    drive3(2'd0, 1'b0, '0, 2'd0, 1'b0);
    drive3(2'd1, 1'b1, 64'h80, 2'd2, 1'b1);
    @(negedge clk);
    assert_count++;
    if (bus3.out_valid !== 3'b000 || drop_count3 !== 16'd1 || bus3.in_ready !== 3'b010) begin
      $display("[TB] FAIL invalid_after actual=%b/%0d/%b required=000/1/010",
               bus3.out_valid, drop_count3, bus3.in_ready); fail_count++;
    end
    next_cycle();
    drive3(2'd1, 1'b0, '0, 2'd0, 1'b0);
    @(negedge clk);
    assert_count++;
    if (bus3.out_valid !== 3'b100 || bus3.out_data[2*DW +: DW] !== 64'h80 ||
        bus3.out_src[4 +: 2] !== 2'd1 || bus3.out_last[2] !== 1'b1 || drop_count3 !== 16'd1) begin
      $display("[TB] FAIL invalid_valid_route actual=%b/%h/%0d/%b/%0d required=100/80/1/1/1",
               bus3.out_valid, bus3.out_data[2*DW +: DW], bus3.out_src[4 +: 2],
               bus3.out_last[2], drop_count3); fail_count++;
    end
    next_cycle();
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_unicast();
    test_contention();
    test_backpressure();
    test_reset_mid_packet();
    test_invalid_dest();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule

// File: doc/xbar_nport_arb.md
Name: xbar_nport_arb

Overview:
- Parametrised N-input / N-output packet crossbar; the next generation of the fixed 2-port select-based crossbar in the Aurora router datapath.
- Each input carries a destination index, so paths are set per packet rather than by an external control code.
- Each output has its own round-robin arbiter, a packet lock held from first beat to last, and a registered output stage with valid/ready backpressure.
- Sits between the Aurora RX input buffers and the TX output queues.

Parameters:
- AURORA_DATA_WIDTH, 64: width of one data beat.
- NUM_PORTS, 4: number of inputs and outputs; legal range 2..8.
- DEST_W, derived localparam: clog2(NUM_PORTS), minimum 1. Not overridable.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_data  in  NUM_PORTS*AURORA_DATA_WIDTH  input beats; port i occupies slice i.
- in_valid  in  NUM_PORTS  beat valid per input.
- in_last  in  NUM_PORTS  last beat of packet per input.
- in_dest  in  NUM_PORTS*DEST_W  destination output index per input; meaningful on the first beat only.
- in_ready  out  NUM_PORTS  beat accepted when in_valid && in_ready on a rising edge.
- out_data  out  NUM_PORTS*AURORA_DATA_WIDTH  registered output beats.
- out_valid  out  NUM_PORTS  output beat valid.
- out_last  out  NUM_PORTS  output last flag.
- out_src  out  NUM_PORTS*DEST_W  index of the input that supplied the beat.
- out_ready  in  NUM_PORTS  downstream accept.
- drop_count  out  16  saturating count of dropped packets.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid, out_last, out_data, out_src all 0.
  - All locks cleared; all round-robin pointers 0; drop_count 0.
  - Every per-input first-beat flag set to 1.
  - in_ready is combinational; with locks cleared it follows the IDLE rules below.
  - Reset mid-packet discards the in-flight packet. No partial-packet recovery; the next beat on each input is treated as a first beat.
- Per-input state:
  - first flag: 1 = next beat is a packet start.
  - lock_out: output index, captured when the first beat transfers with in_last=0.
- Per-output state machine, IDLE / LOCKED:
  - IDLE, request: input i requests output o when in_valid[i], first[i]=1 and in_dest[i]==o.
  - IDLE, arbitration: round-robin starting at pointer rr[o], searching upward and wrapping. At most one grant; the grant is combinational in the same cycle.
  - IDLE, transfer: in_ready[i] = granted && stage_free[o]. On transfer with in_last=0: go to LOCKED(owner=i), rr[o]=i+1 mod NUM_PORTS. On transfer with in_last=1 (single-beat packet): stay in IDLE, rr[o] still advances.
  - LOCKED: only the owner is served; owner in_dest is ignored; in_ready[owner] = in_valid path && stage_free[o]. Other inputs get in_ready=0. The transfer with in_last=1 returns the output to IDLE.
  - stage_free[o] = !out_valid[o] || out_ready[o]. The output register loads on transfer, giving 1-cycle latency from input accept to out_valid. Full throughput is 1 beat/cycle per output when out_ready is held high.
  - If out_valid && !out_ready, the output holds data, last and src stable.
- Invalid destination (in_dest >= NUM_PORTS on a first beat; only possible when NUM_PORTS is not a power of 2):
  - The input enters DROP: in_ready=1 and beats are discarded until and including in_last.
  - drop_count increments once per packet at the first beat, saturating at 16'hFFFF.
- Simultaneous events:
  - An output may accept a new packet's first beat in the same cycle it forwards the previous last beat.
  - Different outputs arbitrate independently; an input is never granted two outputs.
  - A beat with both first=1 and in_last=1 is a complete packet.
- No combinational path from out_ready to out_valid. A path from out_ready to in_ready is permitted.

Test Plan (NUM_PORTS=4, AURORA_DATA_WIDTH=64):
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then release with all in_valid=0.
  - Required: out_valid=0000, drop_count=0. in_ready=0 for every input, since none is requesting.
- Unicast packet:
  - Stimulus: input 2 sends 3 beats 0xA0,0xA1,0xA2 to dest 1, last on the third, out_ready=1.
  - Required: out_data[1] shows the beats on cycles t+1..t+3, out_src[1]=2, out_last[1]=1 only on 0xA2.
- Contention and round-robin:
  - Stimulus: inputs 0 and 3 each send 2-beat packets to dest 0 at the same time.
  - Required: input 0 served first with input 3's in_ready held 0; input 3 follows with no interleaving. On a repeat, input 3 wins.
- Backpressure:
  - Stimulus: out_ready[1]=0 for 4 cycles mid-packet.
  - Required: out_data[1] stays stable, in_ready for the owner drops to 0, no beat lost or duplicated after release.
- Invalid destination (NUM_PORTS=3 build):
  - Stimulus: input 0 sends a 2-beat packet with dest=3.
  - Required: in_ready[0]=1 for both beats, no out_valid asserted, drop_count=1.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 on the second beat of a 4-beat packet, then send a new 1-beat packet.
  - Required: outputs cleared, the new packet is routed by its own in_dest.
